// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge bus between the MEM-stage LSU (master) and data memory (slave).
interface mem_stage_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;

    modport master (
        output req,
        output we,
        output addr,
        output be,
        output wdata,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  be,
        input  wdata,
        output ack,
        output rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: EX/MEM -> MEM/WB with a variable-latency data-memory handshake,
// sub-word loads/stores, misalignment detection and a bus wait-timeout.
module mem_stage_lsu #(
    parameter int ADDR_W   = 32,
    parameter int DEST_W   = 5,
    parameter int OP_W     = 6,
    parameter int MAX_WAIT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              EX_MEM_valid,
    input  logic [31:0]       EX_MEM_result,
    input  logic [31:0]       EX_MEM_B,
    input  logic [DEST_W-1:0] EX_MEM_dest,
    input  logic [OP_W-1:0]   EX_MEM_op,
    input  logic [1:0]        EX_MEM_instruc_type,
    mem_stage_lsu_if.master   dm,
    output logic              mem_stall,
    output logic [31:0]       MEM_WB_result,
    output logic [31:0]       MEM_WB_data,
    output logic [DEST_W-1:0] MEM_WB_dest,
    output logic [OP_W-1:0]   MEM_WB_op,
    output logic [1:0]        MEM_WB_instruc_type,
    output logic              MEM_WB_valid,
    output logic [1:0]        MEM_WB_exc
);
    localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    localparam logic [OP_W-1:0] OP_LB  = OP_W'(6'h20);
    localparam logic [OP_W-1:0] OP_LH  = OP_W'(6'h21);
    localparam logic [OP_W-1:0] OP_LW  = OP_W'(6'h23);
    localparam logic [OP_W-1:0] OP_LBU = OP_W'(6'h24);
    localparam logic [OP_W-1:0] OP_LHU = OP_W'(6'h25);
    localparam logic [OP_W-1:0] OP_SB  = OP_W'(6'h28);
    localparam logic [OP_W-1:0] OP_SH  = OP_W'(6'h29);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(6'h2B);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
            SZ_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] b);
        logic [31:0] w;
        case (size)
            SZ_B:    w = {4{b[7:0]}};
            SZ_H:    w = {2{b[15:0]}};
            default: w = b;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sgn,
                                                input logic [1:0] off, input logic [31:0] rdata);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] r;
        byte_v = rdata[{off, 3'b000} +: 8];
        half_v = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_B:    r = sgn ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
            SZ_H:    r = sgn ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
            SZ_W:    r = rdata;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    state_t            state_r;
    logic [CNT_W-1:0]  wait_cnt_r;
    logic              req_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [3:0]        be_r;
    logic [31:0]       wdata_r;
    logic              load_r;
    logic              sgn_r;
    logic [1:0]        size_r;
    logic [1:0]        off_r;

    logic              is_load_s;
    logic              is_store_s;
    logic              sgn_s;
    logic [1:0]        size_s;
    logic [1:0]        off_s;
    logic              is_mem_s;
    logic              misalign_s;
    logic              aligned_mem_s;
    logic              busy_s;
    logic              start_s;
    logic              done_s;
    logic              timeout_s;
    logic [1:0]        exc_s;

    // Opcode decode into access class, size and signedness
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        sgn_s      = 1'b0;
        size_s     = SZ_W;
        case (EX_MEM_op)
            OP_LB:   begin is_load_s  = 1'b1; size_s = SZ_B; sgn_s = 1'b1; end
            OP_LH:   begin is_load_s  = 1'b1; size_s = SZ_H; sgn_s = 1'b1; end
            OP_LW:   begin is_load_s  = 1'b1; size_s = SZ_W; end
            OP_LBU:  begin is_load_s  = 1'b1; size_s = SZ_B; end
            OP_LHU:  begin is_load_s  = 1'b1; size_s = SZ_H; end
            OP_SB:   begin is_store_s = 1'b1; size_s = SZ_B; end
            OP_SH:   begin is_store_s = 1'b1; size_s = SZ_H; end
            OP_SW:   begin is_store_s = 1'b1; size_s = SZ_W; end
            default: begin is_load_s  = 1'b0; is_store_s = 1'b0; end
        endcase
    end

    assign off_s         = EX_MEM_result[1:0];
    assign is_mem_s      = is_load_s | is_store_s;
    assign misalign_s    = is_mem_s & (((size_s == SZ_H) & off_s[0]) |
                                       ((size_s == SZ_W) & (off_s != 2'b00)));
    assign aligned_mem_s = is_mem_s & ~misalign_s;
    assign busy_s        = (state_r == ST_BUSY);
    assign start_s       = ~busy_s & EX_MEM_valid & aligned_mem_s;
    assign done_s        = busy_s & dm.ack;
    // An ack in the last wait cycle still completes normally.
    assign timeout_s     = busy_s & ~dm.ack & (wait_cnt_r == CNT_LAST);
    assign exc_s         = {timeout_s, EX_MEM_valid & misalign_s};
    assign mem_stall     = ~reset & EX_MEM_valid & aligned_mem_s & ~(done_s | timeout_s);

    assign dm.req   = req_r;
    assign dm.we    = we_r;
    assign dm.addr  = addr_r;
    assign dm.be    = be_r;
    assign dm.wdata = wdata_r;

    // Request FSM with captured, registered bus outputs (all zero while idle)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= '0;
            req_r      <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            be_r       <= 4'b0000;
            wdata_r    <= 32'd0;
            load_r     <= 1'b0;
            sgn_r      <= 1'b0;
            size_r     <= 2'b00;
            off_r      <= 2'b00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    wait_cnt_r <= '0;
                    if (start_s) begin
                        state_r <= ST_BUSY;
                        req_r   <= 1'b1;
                        we_r    <= is_store_s;
                        addr_r  <= {EX_MEM_result[ADDR_W-1:2], 2'b00};
                        be_r    <= lane_be(size_s, off_s);
                        wdata_r <= is_store_s ? lane_wdata(size_s, EX_MEM_B) : 32'd0;
                        load_r  <= is_load_s;
                        sgn_r   <= sgn_s;
                        size_r  <= size_s;
                        off_r   <= off_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (done_s || timeout_s) begin
                        state_r    <= ST_IDLE;
                        wait_cnt_r <= '0;
                        req_r      <= 1'b0;
                        we_r       <= 1'b0;
                        addr_r     <= '0;
                        be_r       <= 4'b0000;
                        wdata_r    <= 32'd0;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    wait_cnt_r <= '0;
                    req_r      <= 1'b0;
                    we_r       <= 1'b0;
                    addr_r     <= '0;
                    be_r       <= 4'b0000;
                    wdata_r    <= 32'd0;
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, otherwise advance the instruction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            MEM_WB_result       <= 32'd0;
            MEM_WB_data         <= 32'd0;
            MEM_WB_dest         <= '0;
            MEM_WB_op           <= '0;
            MEM_WB_instruc_type <= 2'b00;
            MEM_WB_valid        <= 1'b0;
            MEM_WB_exc          <= 2'b00;
        end else if (mem_stall) begin
            MEM_WB_valid <= 1'b0;
            MEM_WB_exc   <= 2'b00;
        end else begin
            MEM_WB_result       <= EX_MEM_result;
            MEM_WB_data         <= (done_s && load_r) ? load_extend(size_r, sgn_r, off_r, dm.rdata)
                                                      : 32'd0;
            MEM_WB_dest         <= EX_MEM_dest;
            MEM_WB_op           <= EX_MEM_op;
            MEM_WB_instruc_type <= EX_MEM_instruc_type;
            MEM_WB_valid        <= EX_MEM_valid & EX_MEM_instruc_type[1] & ~(|exc_s);
            MEM_WB_exc          <= exc_s;
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: loads/stores, lane handling, misalignment, timeout, async reset.
module tb_mem_stage_lsu;
    localparam logic [5:0] OP_ADD = 6'h00;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic        clock;
    logic        reset;
    logic        ex_valid;
    logic [31:0] ex_result;
    logic [31:0] ex_b;
    logic [4:0]  ex_dest;
    logic [5:0]  ex_op;
    logic [1:0]  ex_type;
    logic        mem_stall;
    logic [31:0] wb_result;
    logic [31:0] wb_data;
    logic [4:0]  wb_dest;
    logic [5:0]  wb_op;
    logic [1:0]  wb_type;
    logic        wb_valid;
    logic [1:0]  wb_exc;

    int checks   = 0;
    int failures = 0;

    mem_stage_lsu_if #(.ADDR_W(32)) dm_bus ();

    mem_stage_lsu #(
        .ADDR_W(32), .DEST_W(5), .OP_W(6), .MAX_WAIT(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .EX_MEM_valid(ex_valid),
        .EX_MEM_result(ex_result),
        .EX_MEM_B(ex_b),
        .EX_MEM_dest(ex_dest),
        .EX_MEM_op(ex_op),
        .EX_MEM_instruc_type(ex_type),
        .dm(dm_bus),
        .mem_stall(mem_stall),
        .MEM_WB_result(wb_result),
        .MEM_WB_data(wb_data),
        .MEM_WB_dest(wb_dest),
        .MEM_WB_op(wb_op),
        .MEM_WB_instruc_type(wb_type),
        .MEM_WB_valid(wb_valid),
        .MEM_WB_exc(wb_exc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] res, input logic [31:0] b,
                          input logic [5:0] op, input logic [1:0] ty, input logic [4:0] d);
        ex_valid  = v;
        ex_result = res;
        ex_b      = b;
        ex_op     = op;
        ex_type   = ty;
        ex_dest   = d;
    endtask

    task automatic run_load(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rd,
                            input logic [31:0] exp, input string tag);
        set_ex(1'b1, addr, 32'd0, op, 2'b10, 5'd7);
        step();
        dm_bus.ack   = 1'b1;
        dm_bus.rdata = rd;
        step();
        dm_bus.ack   = 1'b0;
        dm_bus.rdata = 32'd0;
        chk({tag, "_data"}, wb_data, exp);
        chk({tag, "_valid"}, 32'(wb_valid), 32'd1);
        set_ex(1'b0, 32'd0, 32'd0, OP_ADD, 2'b00, 5'd0);
    endtask

    initial begin
        reset        = 1'b1;
        dm_bus.ack   = 1'b0;
        dm_bus.rdata = 32'd0;
        set_ex(1'b0, 32'd0, 32'd0, OP_ADD, 2'b00, 5'd0);
        #2;
        chk("rst_req", 32'(dm_bus.req), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_exc", 32'(wb_exc), 32'd0);
        step();
        reset = 1'b0;

        // lw 0x100, ack on first BUSY cycle
        set_ex(1'b1, 32'h0000_0100, 32'd0, OP_LW, 2'b10, 5'd5);
        #1;
        chk("lw_stall_idle", 32'(mem_stall), 32'd1);
        chk("lw_req_idle", 32'(dm_bus.req), 32'd0);
        step();
        chk("lw_req_busy", 32'(dm_bus.req), 32'd1);
        chk("lw_addr", dm_bus.addr, 32'h0000_0100);
        chk("lw_be", 32'(dm_bus.be), 32'h0000_000F);
        chk("lw_we", 32'(dm_bus.we), 32'd0);
        chk("lw_bubble", 32'(wb_valid), 32'd0);
        dm_bus.ack   = 1'b1;
        dm_bus.rdata = 32'hDEAD_BEEF;
        #1;
        chk("lw_stall_ack", 32'(mem_stall), 32'd0);
        step();
        dm_bus.ack   = 1'b0;
        dm_bus.rdata = 32'd0;
        chk("lw_data", wb_data, 32'hDEAD_BEEF);
        chk("lw_valid", 32'(wb_valid), 32'd1);
        chk("lw_dest", 32'(wb_dest), 32'd5);
        chk("lw_result", wb_result, 32'h0000_0100);
        chk("lw_req_done", 32'(dm_bus.req), 32'd0);

        // sb 0x203: upper lane, replicated byte
        set_ex(1'b1, 32'h0000_0203, 32'h0000_00A5, OP_SB, 2'b00, 5'd0);
        #1;
        chk("sb_stall", 32'(mem_stall), 32'd1);
        step();
        chk("sb_be", 32'(dm_bus.be), 32'h0000_0008);
        chk("sb_wdata", dm_bus.wdata, 32'hA5A5_A5A5);
        chk("sb_we", 32'(dm_bus.we), 32'd1);
        chk("sb_addr", dm_bus.addr, 32'h0000_0200);
        dm_bus.ack = 1'b1;
        step();
        dm_bus.ack = 1'b0;
        chk("sb_wb_valid", 32'(wb_valid), 32'd0);
        chk("sb_wb_data", wb_data, 32'd0);
        chk("sb_we_idle", 32'(dm_bus.we), 32'd0);

        run_load(OP_LB,  32'h0000_0203, 32'h8500_0000, 32'hFFFF_FF85, "lb");
        run_load(OP_LBU, 32'h0000_0203, 32'h8500_0000, 32'h0000_0085, "lbu");
        run_load(OP_LH,  32'h0000_0102, 32'h8001_0000, 32'hFFFF_8001, "lh");
        run_load(OP_LHU, 32'h0000_0102, 32'h8001_0000, 32'h0000_8001, "lhu");
        run_load(OP_LB,  32'h0000_0201, 32'h0000_7F00, 32'h0000_007F, "lb_pos");

        // misaligned lh 0x101
        set_ex(1'b1, 32'h0000_0101, 32'd0, OP_LH, 2'b10, 5'd3);
        #1;
        chk("mis_stall", 32'(mem_stall), 32'd0);
        chk("mis_req", 32'(dm_bus.req), 32'd0);
        step();
        chk("mis_exc", 32'(wb_exc), 32'd1);
        chk("mis_valid", 32'(wb_valid), 32'd0);
        chk("mis_req_after", 32'(dm_bus.req), 32'd0);
        set_ex(1'b1, 32'h0000_0402, 32'h1234_5678, OP_SW, 2'b00, 5'd0);
        step();
        chk("mis_sw_exc", 32'(wb_exc), 32'd1);
        chk("mis_sw_req", 32'(dm_bus.req), 32'd0);
        set_ex(1'b0, 32'd0, 32'd0, OP_ADD, 2'b00, 5'd0);
        step();
        chk("mis_exc_clear", 32'(wb_exc), 32'd0);

        // lw with ack withheld: 16 BUSY cycles then timeout
        set_ex(1'b1, 32'h0000_0300, 32'd0, OP_LW, 2'b10, 5'd9);
        step();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("to_req_%0d", i), 32'(dm_bus.req), 32'd1);
            chk($sformatf("to_stall_%0d", i), 32'(mem_stall), (i == 15) ? 32'd0 : 32'd1);
            step();
        end
        set_ex(1'b0, 32'd0, 32'd0, OP_ADD, 2'b00, 5'd0);
        chk("to_req_low", 32'(dm_bus.req), 32'd0);
        chk("to_exc", 32'(wb_exc), 32'd2);
        chk("to_valid", 32'(wb_valid), 32'd0);
        step();
        chk("to_exc_clear", 32'(wb_exc), 32'd0);

        // lw with ack in the 16th BUSY cycle completes normally
        set_ex(1'b1, 32'h0000_0304, 32'd0, OP_LW, 2'b10, 5'd10);
        step();
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("late_req_%0d", i), 32'(dm_bus.req), 32'd1);
            step();
        end
        dm_bus.ack   = 1'b1;
        dm_bus.rdata = 32'h1234_5678;
        #1;
        chk("late_stall", 32'(mem_stall), 32'd0);
        step();
        dm_bus.ack   = 1'b0;
        dm_bus.rdata = 32'd0;
        set_ex(1'b0, 32'd0, 32'd0, OP_ADD, 2'b00, 5'd0);
        chk("late_data", wb_data, 32'h1234_5678);
        chk("late_exc", 32'(wb_exc), 32'd0);
        chk("late_valid", 32'(wb_valid), 32'd1);

        // ack while idle is ignored
        dm_bus.ack   = 1'b1;
        dm_bus.rdata = 32'hFFFF_FFFF;
        step();
        dm_bus.ack   = 1'b0;
        dm_bus.rdata = 32'd0;
        chk("idle_ack_req", 32'(dm_bus.req), 32'd0);
        chk("idle_ack_data", wb_data, 32'd0);

        // sw interrupted by async reset mid-BUSY
        set_ex(1'b1, 32'h0000_0055, 32'd0, OP_ADD, 2'b10, 5'd4);
        step();
        chk("pre_add_valid", 32'(wb_valid), 32'd1);
        set_ex(1'b1, 32'h0000_0400, 32'hCAFE_F00D, OP_SW, 2'b00, 5'd0);
        step();
        step();
        step();
        chk("rs_req", 32'(dm_bus.req), 32'd1);
        chk("rs_wdata", dm_bus.wdata, 32'hCAFE_F00D);
        chk("rs_stall", 32'(mem_stall), 32'd1);
        chk("rs_hold_result", wb_result, 32'h0000_0055);
        #2;
        reset = 1'b1;
        #1;
        chk("rs_req_async", 32'(dm_bus.req), 32'd0);
        chk("rs_stall_async", 32'(mem_stall), 32'd0);
        chk("rs_result_async", wb_result, 32'd0);
        chk("rs_be_async", 32'(dm_bus.be), 32'd0);
        chk("rs_wdata_async", dm_bus.wdata, 32'd0);
        set_ex(1'b0, 32'd0, 32'd0, OP_ADD, 2'b00, 5'd0);
        #1;
        reset = 1'b0;
        step();
        chk("rs_idle_req", 32'(dm_bus.req), 32'd0);

        // add, lw, add back to back: valid 1,0,1,1
        set_ex(1'b1, 32'h0000_0001, 32'd0, OP_ADD, 2'b10, 5'd1);
        #1;
        chk("b2b_add1_stall", 32'(mem_stall), 32'd0);
        step();
        chk("b2b_v0", 32'(wb_valid), 32'd1);
        set_ex(1'b1, 32'h0000_0500, 32'd0, OP_LW, 2'b10, 5'd2);
        #1;
        chk("b2b_lw_stall", 32'(mem_stall), 32'd1);
        step();
        chk("b2b_v1", 32'(wb_valid), 32'd0);
        dm_bus.ack   = 1'b1;
        dm_bus.rdata = 32'h0000_0011;
        step();
        dm_bus.ack   = 1'b0;
        dm_bus.rdata = 32'd0;
        chk("b2b_v2", 32'(wb_valid), 32'd1);
        chk("b2b_lw_data", wb_data, 32'h0000_0011);
        set_ex(1'b1, 32'h0000_0002, 32'd0, OP_ADD, 2'b10, 5'd3);
        #1;
        chk("b2b_add2_stall", 32'(mem_stall), 32'd0);
        step();
        chk("b2b_v3", 32'(wb_valid), 32'd1);
        chk("b2b_add2_result", wb_result, 32'h0000_0002);
        chk("b2b_add2_data", wb_data, 32'd0);
        set_ex(1'b0, 32'd0, 32'd0, OP_ADD, 2'b00, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
